fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of one FIFO instance among NREQ requesters.
- The FIFO instance uses WRITE_TRIGGER "HIGH" and DEPTH matching this block.
- Sits between peripheral producers (e.g. debug console, UART echo, DMA status) and a shared output FIFO.
- Guarantees that packets from different requesters never interleave, and that no write is issued while the FIFO is full.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; equals FIFO WIDTH.
- DEPTH, 5, FIFO depth exponent; equals FIFO DEPTH.
- STALL_LIMIT, 64, cycles a granted requester may hold valid low mid-packet before forced release (>=2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester data valid
- req_data  input  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  input  NREQ  marks final beat of a packet
- req_ready  output  NREQ  beat accepted when valid&ready on same edge
- fifo_din  output  WIDTH  to FIFO din
- fifo_write  output  1  to FIFO write (level, one beat per cycle)
- fifo_full  input  1  from FIFO full
- grant  output  NREQ  one-hot current owner; 0 when idle
- busy  output  1  high in LOCK state
- abort  output  1  one-cycle pulse on stall-timeout release

Behaviour:
- Reset: state IDLE; grant=0, busy=0, abort=0, req_ready=0, fifo_write=0; priority pointer last=NREQ-1, so requester 0 wins first; stall counter=0.
- State IDLE:
  - If any req_valid, select the first valid index scanning last+1, last+2, ... modulo NREQ.
  - Register grant=onehot(sel) and go to LOCK next cycle.
  - Arbitration latency is 1 cycle; no beat is accepted in IDLE.
- State LOCK (owner g):
  - req_ready[g] = ~fifo_full, combinational from the registered FIFO flag; all other req_ready=0.
  - fifo_write = req_valid[g] & req_ready[g]; fifo_din = req_data slice g (mux output, no register stage).
  - The FIFO updates full on the same edge as a write, so a write in cycle t is reflected in full at t+1; no write ever occurs while full=1.
  - A simultaneous FIFO read and full=1 still blocks the write that cycle: accepted loss of one cycle, never overflow.
  - Accepted beat with req_last[g]=1: next cycle state IDLE, grant=0, last=g.
  - req_ready is 0 in the IDLE cycle, so back-to-back packets from different requesters take 1 idle cycle each.
  - Stall counter:
    - Increments each LOCK cycle with req_valid[g]=0.
    - Clears on any accepted beat, or when valid=1 is blocked by full; a full FIFO never triggers abort.
    - On reaching STALL_LIMIT-1 while still stalling, go to IDLE next cycle, pulse abort for exactly that cycle, set last=g, grant=0.
- Fairness: after release, requester g has lowest priority; with all requesters valid, grants rotate 0,1,2,...,NREQ-1,0.
- Changes to req_valid of non-owners during LOCK have no effect.
- rst asserted mid-packet: all outputs return to reset values on the next edge, partial packet abandoned, no abort pulse. The FIFO is reset by the same rst at system level.
- Single-beat packets (valid and last together) are legal.
- Zero-length packets do not exist.

Test Plan:
- Reset, then req_valid=4'b0101, each requester sending 3-beat packets (data 0xA0..A2 from req0, 0xC0..C2 from req2) -> grant 0001 at cycle 1, FIFO receives A0,A1,A2, one idle cycle, then grant 0100 and C0,C1,C2; no interleave, FIFO load=6.
- All four requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,1; each grant lasts exactly 1 accepted beat; writes occur every second cycle.
- DEPTH=5, no FIFO reads, req1 sends a 40-beat packet -> exactly 32 writes; req_ready=0 and fifo_write=0 while full; after 8 reads are enabled, the remaining 8 beats are accepted in order; abort never pulses.
- req3 granted, sends 2 beats, then drops valid for STALL_LIMIT cycles -> abort pulses once at the release cycle, grant=0 next cycle; a pending req0 is granted on the following cycle (priority now starts at 0).
- rst asserted in the middle of a req2 packet with beats outstanding -> next cycle grant=0, busy=0, fifo_write=0; after release, req0 (pointer reset) wins first.
- req_valid pulses on req1 while req0 holds LOCK -> req_ready[1] stays 0 throughout; req1 is granted immediately after req0's last beat plus 1 idle cycle.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NREQ producers.
// Packets never interleave and no write is issued while the FIFO reports full.
module fifo_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 5,
  parameter int STALL_LIMIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [WIDTH-1:0]       fifo_din,
  output logic                   fifo_write,
  input  logic                   fifo_full,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   abort
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STALL_LIMIT);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  if (NREQ < 2 || NREQ > 8 || DEPTH < 1 || STALL_LIMIT < 2) begin : g_param_check
    $error("fifo_write_arbiter: illegal parameter set");
  end

  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            abort_q, abort_d;

  logic [IW-1:0]   sel;
  logic            any_vld;
  logic            own_valid, own_last;
  logic            lock, accept;
  logic [NREQ-1:0] own_oh;

  // Distance from the pointer: requester last+1 is distance 0, the pointer itself is NREQ-1.
  always_comb begin
    int d;
    int best;
    sel     = last_q;
    any_vld = 1'b0;
    best    = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = i - int'(last_q) - 1;
        if (d < 0) d = d + NREQ;
        if (d < best) begin
          best    = d;
          sel     = IW'(i);
          any_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    fifo_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        fifo_din  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign lock       = (state_q == S_LOCK);
  assign own_oh     = NREQ'(1) << own_q;
  assign accept     = lock & own_valid & ~fifo_full;
  assign req_ready  = (lock & ~fifo_full) ? own_oh : '0;
  assign fifo_write = accept;
  assign grant      = lock ? own_oh : '0;
  assign busy       = lock;
  assign abort      = abort_q;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    stall_d = stall_q;
    abort_d = 1'b0;
    if (state_q == S_IDLE) begin
      stall_d = '0;
      if (any_vld) begin
        own_d   = sel;
        state_d = S_LOCK;
      end
    end else if (accept) begin
      stall_d = '0;
      if (own_last) begin
        state_d = S_IDLE;
        last_d  = own_q;
      end
    end else if (own_valid) begin
      // Blocked by full: back-pressure is not a stall.
      stall_d = '0;
    end else if (stall_q == SW'(STALL_LIMIT - 1)) begin
      state_d = S_IDLE;
      last_d  = own_q;
      abort_d = 1'b1;
      stall_d = '0;
    end else begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end
endmodule
